// File: rtl/alu32_mc.sv
// alu32_mc: handshaked multicycle 32-bit ALU.
// Single-step arith/shift/logic; 32-step shift-add multiply.
module alu32_mc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  op,
  input  logic [3:0]  op1,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] out,
  output logic [31:0] out0,
  output logic        carryout,
  output logic        overflow,
  output logic        zero,
  output logic        N,
  output logic        err
);

  // EXEC is the single compute cycle between accept and response.
  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [3:0]  op1_q, op1_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] prod_q, prod_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] out_q, out_d;
  logic [31:0] out0_q, out0_d;
  logic        cy_q, cy_d;
  logic        ov_q, ov_d;
  logic        z_q, z_d;
  logic        n_q, n_d;
  logic        err_q, err_d;

  logic [31:0] r;
  logic        c;
  logic        v;
  logic        e;
  logic [4:0]  sh;
  logic [31:0] ab;
  logic [32:0] ar;
  logic [63:0] wl;
  logic [63:0] wr;
  logic signed [63:0] wa;
  logic signed [31:0] rs;
  logic [32:0] ms;
  logic [63:0] step;

  // Single-step result and flags from the captured operands.
  always_comb begin
    r  = '0;
    c  = 1'b0;
    v  = 1'b0;
    e  = 1'b0;
    ar = '0;
    sh = b_q[4:0];
    ab = (op1_q[0]) ? 32'd1 : b_q;
    wl = {32'b0, a_q} << sh;
    wr = {a_q, 32'b0} >> sh;
    wa = $signed({a_q, 32'b0}) >>> sh;
    rs = $signed(wl[31:0]) >>> sh;
    unique case (1'b1)
      (op_q == 4'h0): begin
        unique case (op1_q)
          4'h0, 4'h1: begin
            ar = {1'b0, a_q} + {1'b0, ab};
            r  = ar[31:0];
            c  = ar[32];
            v  = (a_q[31] == ab[31]) && (r[31] != a_q[31]);
          end
          4'h2, 4'h3: begin
            ar = {1'b0, a_q} - {1'b0, ab};
            r  = ar[31:0];
            c  = ar[32];
            v  = (a_q[31] != ab[31]) && (r[31] != a_q[31]);
          end
          default: e = 1'b1;
        endcase
      end
      (op_q == 4'h1): begin
        unique case (op1_q)
          4'h0: begin
            r = wl[31:0];
            c = wl[32];
          end
          4'h1: begin
            r = wr[63:32];
            c = wr[31];
          end
          4'h2: begin
            r = wa[63:32];
            c = wa[31];
          end
          4'h3: begin
            r = wl[31:0];
            c = wl[32];
            // lossless iff shifting back restores the operand
            v = (rs != $signed(a_q));
          end
          default: e = 1'b1;
        endcase
      end
      (op_q == 4'h2): begin
        unique case (op1_q)
          4'h0: r = a_q & b_q;
          4'h1: r = a_q | b_q;
          4'h2: r = a_q ^ b_q;
          4'h3: r = {a_q[15:0], a_q[31:16]};
          4'h4: r = ~a_q;
          default: e = 1'b1;
        endcase
      end
      default: e = 1'b1;
    endcase
  end

  // One shift-add multiply step: add multiplicand into high half, shift right.
  always_comb begin
    ms   = {1'b0, prod_q[63:32]} +
           (prod_q[0] ? {1'b0, a_q} : 33'd0);
    step = {ms, prod_q[31:1]};
  end

  // Next-state and register updates for the handshake FSM.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    op1_d   = op1_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    out0_d  = out0_q;
    cy_d    = cy_q;
    ov_d    = ov_q;
    z_d     = z_q;
    n_d     = n_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d   = op;
          op1_d  = op1;
          a_d    = in0;
          b_d    = in1;
          cnt_d  = '0;
          prod_d = {32'b0, in1};
          if (op == 4'h3 && op1 == 4'h0) begin
            state_d = S_MUL;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        out_d   = r;
        out0_d  = '0;
        cy_d    = c;
        ov_d    = v;
        z_d     = (r == 32'd0);
        n_d     = r[31];
        err_d   = e;
        state_d = S_RESP;
      end
      S_MUL: begin
        if (cnt_q == 6'd32) begin
          out_d   = prod_q[63:32];
          out0_d  = prod_q[31:0];
          cy_d    = 1'b0;
          ov_d    = (prod_q[63:32] != 32'd0);
          z_d     = (prod_q == 64'd0);
          n_d     = prod_q[63];
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          prod_d = step;
          cnt_d  = cnt_q + 6'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      op1_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      out0_q  <= '0;
      cy_q    <= 1'b0;
      ov_q    <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      op1_q   <= op1_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      out0_q  <= out0_d;
      cy_q    <= cy_d;
      ov_q    <= ov_d;
      z_q     <= z_d;
      n_q     <= n_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign out       = out_q;
  assign out0      = out0_q;
  assign carryout  = cy_q;
  assign overflow  = ov_q;
  assign zero      = z_q;
  assign N         = n_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu32_mc.sv
// tb_alu32_mc: directed and randomized checks of alu32_mc
// against an arithmetic reference model.
module tb_alu32_mc;

  typedef logic [68:0] res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  op = '0;
  logic [3:0]  op1 = '0;
  logic [31:0] in0 = '0;
  logic [31:0] in1 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] out;
  logic [31:0] out0;
  logic        carryout;
  logic        overflow;
  logic        zero;
  logic        N;
  logic        err;

  int npass = 0;
  int ntotal = 0;

  alu32_mc dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .op1(op1), .in0(in0), .in1(in1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .out(out), .out0(out0),
    .carryout(carryout), .overflow(overflow),
    .zero(zero), .N(N), .err(err)
  );

  always #5 clk = ~clk;

  function automatic res_t obs();
    return {out, out0, carryout, overflow, zero, N, err};
  endfunction

  function automatic logic ovf(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic res_t model(input logic [3:0] o, input logic [3:0] o1,
                                 input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r = '0;
    logic [31:0] r0 = '0;
    logic c = 1'b0;
    logic v = 1'b0;
    logic e = 1'b0;
    logic z;
    int sh = int'(b[4:0]);
    longint unsigned p;
    logic [31:0] bb = (o1 == 4'h1 || o1 == 4'h3) ? 32'd1 : b;
    z = 1'b0;
    if (o == 4'h0 && o1 <= 4'h1) begin
      p = 64'(a) + 64'(bb);
      r = p[31:0];
      c = p[32];
      v = ovf(longint'($signed(a)) + longint'($signed(bb)));
    end else if (o == 4'h0 && o1 <= 4'h3) begin
      r = a - bb;
      c = (a < bb);
      v = ovf(longint'($signed(a)) - longint'($signed(bb)));
    end else if (o == 4'h1 && o1 <= 4'h3) begin
      if (o1 == 4'h0 || o1 == 4'h3) begin
        r = a << sh;
        c = (sh == 0) ? 1'b0 : a[32 - sh];
      end else if (o1 == 4'h1) begin
        r = a >> sh;
        c = (sh == 0) ? 1'b0 : a[sh - 1];
      end else begin
        r = $signed(a) >>> sh;
        c = (sh == 0) ? 1'b0 : a[sh - 1];
      end
      if (o1 == 4'h3) begin
        v = ovf(longint'($signed(a)) * (64'sd1 <<< sh));
      end
    end else if (o == 4'h2 && o1 <= 4'h4) begin
      case (o1)
        4'h0: r = a & b;
        4'h1: r = a | b;
        4'h2: r = a ^ b;
        4'h3: r = {a[15:0], a[31:16]};
        default: r = ~a;
      endcase
    end else if (o == 4'h3 && o1 == 4'h0) begin
      p = 64'(a) * 64'(b);
      r = p[63:32];
      r0 = p[31:0];
      v = (r != 0);
      z = (p == 0);
    end else begin
      e = 1'b1;
    end
    if (!(o == 4'h3 && o1 == 4'h0)) z = (r == 0);
    return {r, r0, c, v, z, r[31], e};
  endfunction

  // one transaction: returns response, latency and protocol-violation flag
  task automatic run_op(input logic [3:0] o, input logic [3:0] o1,
                        input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit early,
                        output res_t r, output int lat, output bit bad);
    int w = 0;
    bad = 1'b0;
    @(negedge clk);
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    op = o; op1 = o1; in0 = a; in1 = b;
    req_valid = 1'b1;
    if (early) rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    op = 4'($urandom); op1 = 4'($urandom);
    in0 = $urandom; in1 = $urandom;
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      if (req_ready) bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    r = obs();
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (obs() !== r || !rsp_valid || req_ready) bad = 1'b1;
      end
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    if (rsp_valid || !req_ready) bad = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    ntotal++;
    if ({obs(), req_ready, rsp_valid} !== {69'd0, 1'b1, 1'b0}) begin
      $display("FAIL reset: got %h rr=%b rv=%b want 0 rr=1 rv=0",
               obs(), req_ready, rsp_valid);
    end else npass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [3:0]  to[10]  = '{0, 0, 0, 0, 0, 1, 2, 2, 2, 3};
    logic [3:0]  to1[10] = '{0, 0, 2, 3, 2, 1, 3, 4, 7, 0};
    logic [31:0] ta[10]  = '{32'h0000ABCD, 32'h81010100, 32'h81111000,
                             32'h0, 32'h0, 32'h09000020, 32'h56561111,
                             32'h9, 32'h12345678, 32'h40000000};
    logic [31:0] tb[10]  = '{32'h7FFFFFFF, 32'h80000000, 32'h61010000,
                             32'h5, 32'h0, 32'h7, 32'h0, 32'h0,
                             32'h1, 32'h8};
    res_t te[10] = '{
      {32'h8000ABCC, 32'h0, 5'b01010},
      {32'h01010100, 32'h0, 5'b11000},
      {32'h20101000, 32'h0, 5'b01000},
      {32'hFFFFFFFF, 32'h0, 5'b10010},
      {32'h00000000, 32'h0, 5'b00100},
      {32'h00120000, 32'h0, 5'b00000},
      {32'h11115656, 32'h0, 5'b00000},
      {32'hFFFFFFF6, 32'h0, 5'b00010},
      {32'h00000000, 32'h0, 5'b00101},
      {32'h00000002, 32'h0, 5'b01000}};
    res_t r;
    int lat;
    bit bad;
    for (int i = 0; i < 10; i++) begin
      run_op(to[i], to1[i], ta[i], tb[i], 0, 1'b0, r, lat, bad);
      ntotal++;
      if (r !== te[i]) begin
        $display("FAIL directed[%0d] result: got %h want %h", i, r, te[i]);
      end else npass++;
      ntotal++;
      if (lat !== ((i == 9) ? 33 : 1) || bad) begin
        $display("FAIL directed[%0d] timing: lat=%0d bad=%b want lat=%0d bad=0",
                 i, lat, bad, (i == 9) ? 33 : 1);
      end else npass++;
    end
  endtask

  task automatic test_random();
    res_t r;
    res_t x;
    int lat;
    bit bad;
    logic [3:0] o;
    logic [3:0] o1;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 160; i++) begin
      o  = 4'($urandom_range(0, 4));
      o1 = (o == 4'h3 && $urandom_range(0, 3) != 0) ? 4'h0
                                                    : 4'($urandom_range(0, 6));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 4) == 0) a = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'h0;
      if ($urandom_range(0, 4) == 0) b = 32'($urandom_range(0, 1)) << 31;
      x = model(o, o1, a, b);
      run_op(o, o1, a, b, $urandom_range(0, 3),
             ($urandom_range(0, 5) == 0), r, lat, bad);
      ntotal++;
      if (r !== x) begin
        $display("FAIL random[%0d] op=%h/%h a=%h b=%h: got %h want %h",
                 i, o, o1, a, b, r, x);
      end else npass++;
      ntotal++;
      if (lat !== ((o == 4'h3 && o1 == 4'h0) ? 33 : 1) || bad) begin
        $display("FAIL random[%0d] timing: lat=%0d bad=%b", i, lat, bad);
      end else npass++;
    end
  endtask

  task automatic test_backpressure();
    res_t r;
    res_t x;
    bit bad = 1'b0;
    @(negedge clk);
    op = 4'h0; op1 = 4'h0; in0 = 32'h11; in1 = 32'h22;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op = 4'h2; op1 = 4'h2; in0 = 32'hF0F0F0F0; in1 = 32'h0FF00FF0;
    @(negedge clk);
    r = obs();
    ntotal++;
    if (!rsp_valid || r !== model(4'h0, 4'h0, 32'h11, 32'h22)) begin
      $display("FAIL bp_first: rv=%b got %h want %h", rsp_valid, r,
               model(4'h0, 4'h0, 32'h11, 32'h22));
    end else npass++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (obs() !== r || !rsp_valid || req_ready) bad = 1'b1;
    end
    ntotal++;
    if (bad) begin
      $display("FAIL bp_hold: got %h rv=%b rr=%b want stable %h", obs(),
               rsp_valid, req_ready, r);
    end else npass++;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    ntotal++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      $display("FAIL bp_release: rv=%b rr=%b want rv=0 rr=1", rsp_valid, req_ready);
    end else npass++;
    @(negedge clk);
    req_valid = 1'b0;
    ntotal++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      $display("FAIL bp_second_accept: rv=%b rr=%b want rv=0 rr=0",
               rsp_valid, req_ready);
    end else npass++;
    @(negedge clk);
    x = model(4'h2, 4'h2, 32'hF0F0F0F0, 32'h0FF00FF0);
    ntotal++;
    if (!rsp_valid || obs() !== x) begin
      $display("FAIL bp_second: rv=%b got %h want %h", rsp_valid, obs(), x);
    end else npass++;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_mul();
    res_t r;
    int lat;
    bit bad = 1'b0;
    @(negedge clk);
    op = 4'h3; op1 = 4'h0; in0 = 32'hDEADBEEF; in1 = 32'h12345679;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    ntotal++;
    if ({obs(), req_ready, rsp_valid} !== {69'd0, 1'b1, 1'b0}) begin
      $display("FAIL mid_mul_reset: got %h rr=%b rv=%b want 0 rr=1 rv=0",
               obs(), req_ready, rsp_valid);
    end else npass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) bad = 1'b1;
    end
    ntotal++;
    if (bad) begin
      $display("FAIL stale_rsp: rsp_valid seen after reset, want 0");
    end else npass++;
    run_op(4'h0, 4'h0, 32'h1, 32'h16, 0, 1'b0, r, lat, bad);
    ntotal++;
    if (r[68:37] !== 32'h17 || lat !== 1 || bad) begin
      $display("FAIL post_reset_add: got %h lat=%0d bad=%b want 17 lat=1",
               r[68:37], lat, bad);
    end else npass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/alu32_mc.md
# alu32_mc

Multicycle, handshaked responder around the 32-bit ALU operation set. An initiator presents an `op`/`op1` pair and two operands over a valid/ready request channel. The block computes the result (single-step for arithmetic, shift and logic ops; iterative 32-step shift-add for multiply) and returns result and flags over a valid/ready response channel. It sits between an instruction/command sequencer and the register or trace sink, and replaces direct combinational ALU use where results must be registered and back-pressured.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `op` in 4: operation class.
  - 0000 arithmetic
  - 0001 shift
  - 0010 logic
  - 0011 multiply
- `op1` in 4: sub-operation within the class (see Operation).
- `in0` in 32: operand A.
- `in1` in 32: operand B, or shift amount in `in1[4:0]`.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: sink accepts the response.
- `out` in 32 is wrong; `out` out 32: result, or multiply high word.
- `out0` out 32: multiply low word; 0 for every non-multiply op.
- `carryout`, `overflow`, `zero`, `N` out 1 each: result flags.
- `err` out 1: illegal `op`/`op1` combination.

## Operation
- FSM states:
  - IDLE: `req_ready`=1.
  - MUL: multiply iterations.
  - RESP: `rsp_valid`=1.
- IDLE transitions on `req_valid`: a multiply request goes to MUL; any other request computes, registers its result and goes to RESP.
- MUL runs exactly 32 cycles, then goes to RESP.
- RESP goes to IDLE on `rsp_ready`.
- Operands are captured at accept; input changes after accept have no effect.
- Arithmetic (`op`=0000):
  - `op1`=0000 add: `in0+in1`.
  - 0001 inc: `in0+1`.
  - 0010 sub: `in0-in1`.
  - 0011 dec: `in0-1`. `in1` is ignored for inc and dec.
  - `carryout`: carry out of bit 31 for add/inc; borrow (unsigned `in0` < subtrahend) for sub/dec.
  - `overflow`: two's-complement signed overflow.
- Shift (`op`=0001), `sh`=`in1[4:0]`:
  - 0000 logical left.
  - 0001 logical right.
  - 0010 arithmetic right.
  - 0011 arithmetic left: zero fill, with `overflow`=1 if any shifted-out bit or the resulting sign differs from the original sign.
  - `carryout` = last bit shifted out; 0 when `sh`=0.
  - `overflow`=0 except for arithmetic left.
- Logic (`op`=0010):
  - 0000 AND.
  - 0001 OR.
  - 0010 XOR.
  - 0011 swap halves `{in0[15:0],in0[31:16]}`.
  - 0100 NOT `in0`.
  - `carryout`=`overflow`=0.
- Multiply (`op`=0011, `op1`=0000):
  - Unsigned 32x32 to 64, one shift-add step per cycle.
  - `{out,out0}` = product.
  - `overflow`=1 when `out`≠0.
  - `carryout`=0.
  - `zero` reflects all 64 bits.
- `zero`=(`out`==0) for non-multiply ops; `N`=`out[31]`.
- Any other `op`/`op1` combination: `err`=1, all result and flag outputs 0 except `zero`=1. The response takes the single-step path.

## Timing
- Reset (async assert): FSM goes to IDLE.
  - `req_ready`=1 after reset.
  - `rsp_valid`=0.
  - `out`, `out0`, `carryout`, `overflow`, `N` and `err` = 0.
  - `zero`=0.
  - Deassertion is taken at the next clock edge.
- Non-multiply op accepted at edge t: `rsp_valid`=1 after edge t+1.
- Multiply accepted at edge t: MUL covers edges t+1..t+32; `rsp_valid`=1 after edge t+33.
- Response outputs are held stable while `rsp_valid`=1 and `rsp_ready`=0.
- `req_ready`=0 in MUL and RESP; no overlap between requests.
- Minimum request spacing: 2 cycles for non-multiply ops, 34 for multiply.
- `rsp_ready` asserted before `rsp_valid` is harmless; the handshake completes on the first edge where both are 1.
- Reset mid-MUL or mid-RESP: the operation is abandoned with no response emitted, and all outputs return to reset values.

## Test plan
- Add: `in0`=0x0000ABCD, `in1`=0x7FFFFFFF → `out`=0x8000ABCC, `overflow`=1, `N`=1, `carryout`=0. Also 0x81010100+0x80000000 → `out`=0x01010100, `carryout`=1, `overflow`=1. Each response appears 1 cycle after accept.
- Sub/dec: 0x81111000−0x61010000 → 0x20101000 with `overflow`=1, `carryout`=0. Dec of 0 → 0xFFFFFFFF with `carryout`=1, `N`=1. Sub 0−0 → `zero`=1.
- Shift/logic:
  - Logical right 0x09000020 by 7 → 0x00120000, `carryout`=0.
  - Swap 0x56561111 → 0x11115656.
  - NOT 0x00000009 → 0xFFFFFFF6.
  - Illegal `op`=0010, `op1`=0111 → `err`=1.
- Multiply 0x40000000×0x00000008: `out`=0x00000002, `out0`=0x00000000, `overflow`=1. `rsp_valid` appears exactly 33 cycles after accept and `req_ready`=0 throughout.
- Back-pressure: hold `rsp_ready`=0 for 10 cycles → outputs stable, `req_ready`=0, and a second `req_valid` is not accepted until 1 cycle after the response handshake.
- Reset: assert `rst_n`=0 at MUL cycle 15 → outputs return to reset values immediately. After release, a new add 0x1+0x16 returns 0x17 with no stale response.
